mem_load_writer: RTL

Synthesizable load engine between the FVE memory loader and the DUT program/data memory write port. The loader pulls image words out of the Codasip memory model and streams them in; this block buffers them, writes them to consecutive byte addresses through an acknowledged write port, and accumulates a checksum. It holds the core in reset until the whole image is committed, so both the instruction-accurate (IA) and cycle-accurate (CA) models start from identical memory.

---
 rtl/mem_load_writer.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/mem_load_writer.sv
// Load engine: buffers loader image words, writes them to consecutive byte
// addresses through an acknowledged port, sums them, and gates core reset.
module mem_load_writer #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int CNT_W      = 20,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              CLK,
    input  logic              RST_n,
    input  logic              START,
    input  logic [ADDR_W-1:0] BASE_ADDR,
    input  logic [CNT_W-1:0]  WORD_CNT,
    input  logic [DATA_W-1:0] IN_DATA,
    input  logic              IN_VALID,
    output logic              IN_READY,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0] MEM_WDATA,
    output logic              MEM_WE,
    input  logic              MEM_ACK,
    output logic              BUSY,
    output logic              DONE,
    output logic [31:0]       CHECKSUM,
    output logic              CORE_RST_n
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_FIN   = 2'd3;

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  r_acc;
    logic [CNT_W-1:0]  r_com;
    logic [31:0]       r_sum;
    logic              r_busy;
    logic              r_done;
    logic              r_core_rst_n;

    logic [DATA_W-1:0] r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [PTR_W:0]    r_level;

    logic              w_full;
    logic              w_empty;
    logic              w_ready;
    logic              w_we;
    logic              w_push;
    logic              w_pop;
    logic [DATA_W-1:0] w_head;
    logic [31:0]       w_head32;

    assign w_full   = (r_level == (PTR_W + 1)'(FIFO_DEPTH));
    assign w_empty  = (r_level == '0);
    assign w_ready  = (r_state == S_LOAD) && !w_full && (r_acc < r_cnt);
    assign w_we     = ((r_state == S_LOAD) || (r_state == S_DRAIN)) && !w_empty;
    assign w_push   = IN_VALID && w_ready;
    assign w_pop    = w_we && MEM_ACK;
    assign w_head   = r_fifo[r_rptr];

    // Checksum is always 32 bits regardless of the word width.
    generate
        if (DATA_W >= 32) begin : g_trunc
            assign w_head32 = w_head[31:0];
        end else begin : g_zext
            assign w_head32 = {{(32 - DATA_W){1'b0}}, w_head};
        end
    endgenerate

    assign IN_READY   = w_ready;
    assign MEM_WE     = w_we;
    assign MEM_WDATA  = w_we ? w_head : '0;
    assign MEM_ADDR   = r_addr;
    assign BUSY       = r_busy;
    assign DONE       = r_done;
    assign CHECKSUM   = r_sum;
    assign CORE_RST_n = r_core_rst_n;

    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_fifo[r_wptr] <= IN_DATA;
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_state      <= S_IDLE;
            r_addr       <= '0;
            r_cnt        <= '0;
            r_acc        <= '0;
            r_com        <= '0;
            r_sum        <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_core_rst_n <= 1'b0;
        end else begin
            if (w_push) r_acc <= r_acc + 1'b1;
            if (w_pop) begin
                r_addr <= r_addr + ADDR_W'(DATA_W / 8);
                r_sum  <= r_sum + w_head32;
                r_com  <= r_com + 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (START) begin
                        r_addr       <= BASE_ADDR;
                        r_cnt        <= WORD_CNT;
                        r_acc        <= '0;
                        r_com        <= '0;
                        r_sum        <= '0;
                        r_done       <= 1'b0;
                        r_busy       <= 1'b1;
                        r_core_rst_n <= 1'b0;
                        r_state      <= (WORD_CNT == '0) ? S_FIN : S_LOAD;
                    end else if (r_done) begin
                        r_core_rst_n <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (w_push && ((r_acc + 1'b1) == r_cnt)) r_state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (w_pop && ((r_com + 1'b1) == r_cnt)) r_state <= S_FIN;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
